// File: rtl/atanh_series_if.sv
// atanh_series_if: start/done handshake bundle for the atanh_series unit.
//   start  - request, Q1.15 operand x_in sampled with it while busy is low
//   x_in   - operand, Q1.15 signed
//   busy   - unit occupied (accepted start through done cycle inclusive)
//   done   - one-cycle pulse, y_out valid in that cycle
//   y_out  - result, Q1.15 signed, held until the next done
// master: requester side, slave: the atanh_series unit.
interface atanh_series_if;
  logic        start;
  logic [15:0] x_in;
  logic        busy;
  logic        done;
  logic [15:0] y_out;

  modport master (
    output start,
    output x_in,
    input  busy,
    input  done,
    input  y_out
  );

  modport slave (
    input  start,
    input  x_in,
    output busy,
    output done,
    output y_out
  );
endinterface

// File: rtl/atanh_series.sv
// atanh_series: iterative atanh(x) = sum x^(2k+1)/(2k+1), k = 0..N_TERMS-1, in Q1.15.
// Works on the magnitude with one shared 16x16 unsigned multiplier and a 1/(2k+1) ROM,
// then reapplies the sign. The accumulator saturates at 0x7FFF, so results never reach 0x8000.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - atanh_series_if.slave (start, x_in, busy, done, y_out)
// Parameters:
//   N_TERMS - number of series terms, 2..8
// Build option:
//   ATANH_ROUND_EN - when defined, every multiply rounds half up instead of truncating.
module atanh_series #(
  parameter int unsigned N_TERMS = 8
) (
  input logic           clk,
  input logic           rst,
  atanh_series_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQR  = 2'd1;
  localparam logic [1:0] S_POW  = 2'd2;
  localparam logic [1:0] S_MAC  = 2'd3;

  localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

  logic [1:0]  r_state;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [15:0] r_x2;
  logic [15:0] r_power;
  logic [15:0] r_acc;
  logic [2:0]  r_k;
  logic        r_done;
  logic [15:0] r_y;

  logic        w_busy;
  logic [15:0] w_abs;
  logic [15:0] w_mul_a;
  logic [15:0] w_mul_b;
  logic [31:0] w_prod;
  logic [15:0] w_mul;
  logic [15:0] w_coef;
  logic [16:0] w_sum;
  logic [15:0] w_acc_sat;
  logic [15:0] w_y_next;

  assign w_busy    = (r_state != S_IDLE) || r_done;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.y_out = r_y;

  // -0x8000 has no positive Q1.15 counterpart; clamp it to the largest magnitude.
  always_comb begin
    w_abs = bus.x_in;
    if (bus.x_in == 16'h8000) begin
      w_abs = 16'h7FFF;
    end else if (bus.x_in[15]) begin
      w_abs = 16'(~bus.x_in + 16'd1);
    end
  end

  always_comb begin
    w_coef = 16'h0000;
    case (r_k)
      3'd1:    w_coef = 16'h2AAB;
      3'd2:    w_coef = 16'h199A;
      3'd3:    w_coef = 16'h1249;
      3'd4:    w_coef = 16'h0E39;
      3'd5:    w_coef = 16'h0BA3;
      3'd6:    w_coef = 16'h09D9;
      3'd7:    w_coef = 16'h0889;
      default: w_coef = 16'h0000;
    endcase
  end

  // Shared multiplier operand select: mag^2 in SQR, power*coef in MAC, power*x2 otherwise.
  always_comb begin
    w_mul_a = r_power;
    w_mul_b = r_x2;
    case (r_state)
      S_SQR: begin
        w_mul_a = r_mag;
        w_mul_b = r_mag;
      end
      S_MAC: begin
        w_mul_a = r_power;
        w_mul_b = w_coef;
      end
      default: begin
        w_mul_a = r_power;
        w_mul_b = r_x2;
      end
    endcase
  end

`ifdef ATANH_ROUND_EN
  assign w_prod = ({16'h0000, w_mul_a} * {16'h0000, w_mul_b}) + 32'h0000_4000;
`else
  assign w_prod = {16'h0000, w_mul_a} * {16'h0000, w_mul_b};
`endif
  // Operands are < 1.0, so bits [30:15] hold the Q1.15 product.
  assign w_mul = 16'(w_prod >> 15);

  assign w_sum     = {1'b0, r_acc} + {1'b0, w_mul};
  assign w_acc_sat = (w_sum > 17'h07FFF) ? 16'h7FFF : w_sum[15:0];
  assign w_y_next  = r_sign ? 16'(~w_acc_sat + 16'd1) : w_acc_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_mag   <= 16'h0000;
      r_x2    <= 16'h0000;
      r_power <= 16'h0000;
      r_acc   <= 16'h0000;
      r_k     <= 3'd0;
      r_done  <= 1'b0;
      r_y     <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !w_busy) begin
            r_sign  <= bus.x_in[15];
            r_mag   <= w_abs;
            r_power <= w_abs;
            r_acc   <= w_abs;
            r_k     <= 3'd1;
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          r_x2    <= w_mul;
          r_state <= S_POW;
        end
        S_POW: begin
          r_power <= w_mul;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= w_acc_sat;
          if (r_k == K_LAST) begin
            r_y     <= w_y_next;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_k     <= r_k + 3'd1;
            r_state <= S_POW;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/atanh_series.md
Name: atanh_series

Overview:
- Iterative inverse-hyperbolic-tangent unit; pairs with the tanh engine so firmware and the test bench can round-trip y = tanh(x) -> x.
- Evaluates atanh(x) = sum over k of x^(2k+1)/(2k+1) in Q1.15 two's complement.
- One shared 16x16 unsigned multiplier, a coefficient ROM and an FSM-owned start/done handshake.
- Single-issue: one evaluation in flight at a time.

Parameters:
N_TERMS, 8, number of series terms (k = 0..N_TERMS-1); legal range 2..8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only while busy=0
x_in  input  16  operand, Q1.15 signed
busy  output  1  high from accepted start until the done cycle, inclusive
done  output  1  one-cycle pulse; y_out is valid in that cycle
y_out  output  16  result, Q1.15 signed; held until the next done

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, y_out=0x0000; all internal registers cleared.
- Internal registers: mag, sign, x2, power, acc (16 b unsigned Q1.15 magnitudes); k (3 b).
- mul(a,b) = (a*b)[30:15], 32-bit unsigned product.
- Coefficient ROM, 1/(2k+1) in Q1.15, k=1..7: 0x2AAB, 0x199A, 0x1249, 0x0E39, 0x0BA3, 0x09D9, 0x0889. There is no k=0 entry; the k=0 term is mag itself.
- IDLE:
  - busy=0.
  - On start=1: sign <= x_in[15]; mag <= |x_in|, with x_in=0x8000 mapped to 0x7FFF; power <= the same magnitude; acc <= the same magnitude; k <= 1; go to SQR.
- SQR: x2 <= mul(mag,mag); go to POW.
- POW: power <= mul(power,x2); go to MAC.
- MAC:
  - acc <= min(acc + mul(power, rom[k]), 0x7FFF), using a 17-bit add with saturation.
  - If k == N_TERMS-1: load y_out (sign ? -acc : acc), pulse done, go to IDLE.
  - Otherwise: k <= k+1; go to POW.
- busy = (state != IDLE) or done.
- Latency:
  - Start sampled at edge E0; done and y_out update at edge E0 + 2*N_TERMS - 1.
  - N_TERMS=8: 15 cycles.
  - Throughput: one result per 2*N_TERMS cycles. Start is accepted the cycle after done, at the earliest.
- Start while busy=1: ignored entirely; no queueing, no effect on the computation in flight.
- Start held high continuously: back-to-back operations, each on the x_in present at its accepting edge.
- x_in changes during an operation: no effect; the operand is latched at start.
- Saturation:
  - Once acc reaches 0x7FFF it stays at 0x7FFF.
  - Positive saturated result = 0x7FFF; negative saturated result = 0x8001. 0x8000 is never produced.
- Zero input: all products are 0; y_out=0x0000. Sign of zero is ignored because -0 = 0.

Optional Feature:
- Macro ATANH_ROUND_EN.
- Defined: every mul() adds 0x4000 to the 32-bit product before taking bits [30:15] (round half up).
- Undefined: plain truncation.
- Latency, handshake and saturation are identical in both builds.

Test Plan:
- Reset with start=0, then 5 idle cycles: busy=0, done=0, y_out=0x0000 throughout.
- x_in=0x0000, start 1 cycle: done exactly 15 cycles later, y_out=0x0000, busy high for 16 cycles.
- x_in=0x4000 (0.5): y_out=0x464F ±6 LSB (atanh 0.5 = 0.54931); then x_in=0xC000: y_out=0xB9B1 ±6 LSB, and the two results are exact bitwise negations.
- x_in=0x7FFF, then x_in=0x8000: y_out=0x7FFF and 0x8001 respectively (saturation); no 0x8000 ever observed.
- Start pulsed with x_in=0x2000 at cycles +3 and +10 after an accepted x_in=0x1000 start: only one done, at +15, with y_out ≈ atanh(0.125)=0x1015 ±4 LSB; the next start is accepted only after done.
- Assert rst at cycle +7 of an operation: outputs clear immediately (async), no done pulse; a new start after reset release completes normally in 15 cycles.
